icache_refill_ctrl: RTL and testbench
=====================================

// Module: icache_refill_ctrl
// PURPOSE
//  L1 I-cache miss/refill sequencer (L1ICtrl): accepts a miss from IFetch and requests the line from memory.
//  Streams returned beats into the icache data array, then issues the single-cycle tag fill to instr_cache_tag.
//  Handles one outstanding miss at a time; busy stalls IFetch.
// PARAMETERS
//  CACHELINE_SIZE       16  line size in bytes
//  CACHELINE_SIZE_BITS  4   log2(CACHELINE_SIZE)
//  NUM_ENTRIES_BITS     5   index width into data/tag arrays
//  BEAT_BYTES           4   bytes per memory beat; NUM_BEATS = CACHELINE_SIZE/BEAT_BYTES (=4)
// PORTS
//  i_clk            in   1      clock
//  i_rst_n          in   1      reset: synchronous, active-low
//  i_clear          in   1      cache flush (same signal as tag array i_clear)
//  i_miss           in   1      IFetch miss request; held until o_refill_done
//  i_miss_paddr     in   paddr_t  physical address of missing fetch
//  o_busy           out  1      refill in progress (IFetch stall)
//  o_mem_req        out  1      memory read request, held until i_mem_ack
//  o_mem_addr       out  paddr_t  line-aligned address (low CACHELINE_SIZE_BITS zero)
//  i_mem_ack        in   1      request accepted this cycle
//  i_mem_valid      in   1      response beat valid
//  i_mem_data       in   8*BEAT_BYTES  response beat data, beats in ascending address order
//  o_data_we        out  1      data array write strobe
//  o_data_idx       out  NUM_ENTRIES_BITS  line index = paddr[CSB+NEB-1:CSB]
//  o_data_beat      out  log2(NUM_BEATS)   beat slot within line
//  o_data_wdata     out  8*BEAT_BYTES      beat data
//  o_fill           out  1      tag fill strobe (to tag i_fill)
//  o_fill_paddr     out  paddr_t  line-aligned fill address
//  o_refill_done    out  1      one-cycle completion pulse to IFetch
// BEHAVIOUR
//  Reset (i_rst_n=0 at posedge): state IDLE, beat counter 0, abort flag 0; all outputs 0.
//  FSM IDLE->REQ->RECV->FILL->IDLE.
//   IDLE: i_miss=1 -> latch line_addr = i_miss_paddr with low CSB bits cleared; go REQ. o_busy=0 only here.
//   REQ: o_mem_req=1, o_mem_addr=line_addr; on i_mem_ack go RECV. Ack in the first REQ cycle is legal.
//   RECV: each i_mem_valid cycle -> o_data_we=1 combinationally in that cycle, o_data_beat=counter,
//     o_data_wdata=i_mem_data, counter++. Beat NUM_BEATS-1 -> counter wraps to 0, go FILL.
//     i_mem_valid gaps allowed, no timeout. Beats before ack are ignored.
//   FILL: one cycle; o_fill=1 (unless aborted), o_fill_paddr=line_addr, o_refill_done=1; go IDLE.
//  Min latency miss->done: 1 (IDLE) + 1 (REQ, ack) + NUM_BEATS (RECV) + 1 (FILL) = 7 cycles with back-to-back beats.
//  i_miss while busy: ignored; IFetch must not change i_miss_paddr while i_miss=1 and o_busy=1.
//  i_clear:
//   - In IDLE or FILL: no state effect; FILL still pulses o_refill_done.
//   - In FILL, o_fill is forced to 0 when i_clear=1 in the same cycle.
//   - In REQ/RECV: set abort flag. The refill continues to drain all beats (memory protocol must complete);
//     data writes still occur. In FILL with abort=1: o_fill=0 and o_refill_done=1; abort cleared on leaving FILL.
//   - Rationale: a flush must not re-validate a line fetched before it.
//  Reset mid-refill: immediate IDLE. Memory side must not return beats of the abandoned request after reset.
//  o_data_idx derives from line_addr and is stable for the whole refill.
// TESTING
//  1. Miss paddr=0x0000_1234, ack in first REQ cycle, 4 back-to-back beats A0..A3
//     -> mem_addr=0x1230; data_we beats 0..3 at idx 0x03; fill paddr=0x1230 and done pulse at cycle 7.
//  2. Same miss with a 2-cycle ack delay and 1-cycle gaps between beats
//     -> mem_req held 3 cycles; 4 writes only on valid cycles; done at cycle 12.
//  3. i_clear pulse during RECV after beat 1 -> remaining beats written; FILL has o_fill=0, o_refill_done=1.
//  4. New i_miss paddr=0x2000 raised during RECV -> ignored; after done, next IDLE accepts it, mem_addr=0x2000.
//  5. i_rst_n=0 during RECV beat 2 -> next cycle all outputs 0, o_busy=0; fresh miss completes normally.
//  6. Miss paddr=0xFFFF_FFFC (line wrap, idx 0x1F) -> mem_addr=0xFFFF_FFF0, o_data_idx=0x1F; counter returns to 0 after FILL.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// icache_refill_ctrl
//   L1 I-cache miss/refill sequencer. Takes one miss at a time from IFetch,
//   requests the aligned line from memory, streams each returned beat into the
//   data array and finishes with a single-cycle tag fill plus a done pulse.
//   A flush (i_clear) seen while the line is in flight suppresses the tag fill
//   so that a line fetched before the flush is never re-validated.
// -----------------------------------------------------------------------------
module icache_refill_ctrl #(
  parameter  int CACHELINE_SIZE      = 16,
  parameter  int CACHELINE_SIZE_BITS = 4,
  parameter  int NUM_ENTRIES_BITS    = 5,
  parameter  int BEAT_BYTES          = 4,
  parameter  int PADDR_WIDTH         = 32,
  localparam int NUM_BEATS           = CACHELINE_SIZE / BEAT_BYTES,
  localparam int BEAT_IDX_W          = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int BEAT_W              = 8 * BEAT_BYTES
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_clear,
  // IFetch side
  input  logic                        i_miss,
  input  logic [PADDR_WIDTH-1:0]      i_miss_paddr,
  output logic                        o_busy,
  output logic                        o_refill_done,
  // Memory request / response
  output logic                        o_mem_req,
  output logic [PADDR_WIDTH-1:0]      o_mem_addr,
  input  logic                        i_mem_ack,
  input  logic                        i_mem_valid,
  input  logic [BEAT_W-1:0]           i_mem_data,
  // Data array write port
  output logic                        o_data_we,
  output logic [NUM_ENTRIES_BITS-1:0] o_data_idx,
  output logic [BEAT_IDX_W-1:0]       o_data_beat,
  output logic [BEAT_W-1:0]           o_data_wdata,
  // Tag array fill port
  output logic                        o_fill,
  output logic [PADDR_WIDTH-1:0]      o_fill_paddr
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_FILL = 2'd3
  } state_e;

  // Clears the byte-offset bits so every address leaving this block is line aligned.
  localparam logic [PADDR_WIDTH-1:0] LINE_MASK =
    {{(PADDR_WIDTH-CACHELINE_SIZE_BITS){1'b1}}, {CACHELINE_SIZE_BITS{1'b0}}};
  localparam logic [BEAT_IDX_W-1:0]  LAST_BEAT = BEAT_IDX_W'(NUM_BEATS - 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [PADDR_WIDTH-1:0]  r_line_addr;
  logic [PADDR_WIDTH-1:0]  w_line_addr_nxt;
  logic [BEAT_IDX_W-1:0]   r_beat_cnt;
  logic [BEAT_IDX_W-1:0]   w_beat_cnt_nxt;
  logic                    r_abort;
  logic                    w_abort_nxt;

  // State register, line address, beat counter and abort flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      // NOTE: the line address is datapath, but it feeds o_data_idx directly,
      // so it is reset to keep every output at zero straight out of reset.
      r_line_addr <= '0;
      r_beat_cnt  <= '0;
      r_abort     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // values computed by the combinational block in the same cycle.
      r_state     <= w_state_nxt;
      r_line_addr <= w_line_addr_nxt;
      r_beat_cnt  <= w_beat_cnt_nxt;
      r_abort     <= w_abort_nxt;
    end
  end

  // Next-state logic and all outputs, decoded from the current state.
  always_comb begin
    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_state_nxt     = r_state;
    w_line_addr_nxt = r_line_addr;
    w_beat_cnt_nxt  = r_beat_cnt;
    w_abort_nxt     = r_abort;

    o_busy          = 1'b1;
    o_refill_done   = 1'b0;
    o_mem_req       = 1'b0;
    o_mem_addr      = '0;
    o_data_we       = 1'b0;
    o_data_beat     = '0;
    o_data_wdata    = '0;
    o_fill          = 1'b0;
    o_fill_paddr    = '0;

    // The index comes from the latched line so it cannot move mid-refill.
    o_data_idx = r_line_addr[CACHELINE_SIZE_BITS +: NUM_ENTRIES_BITS];

    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_miss) begin
          w_line_addr_nxt = i_miss_paddr & LINE_MASK;
          w_state_nxt     = ST_REQ;
        end
      end

      ST_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_line_addr;
        if (i_clear) begin
          w_abort_nxt = 1'b1;
        end
        // Beats arriving before the ack do not belong to this request.
        if (i_mem_ack) begin
          w_state_nxt = ST_RECV;
        end
      end

      ST_RECV: begin
        // A flush here cannot cancel the memory burst; the beats still drain
        // and are written, only the final tag fill is withheld.
        if (i_clear) begin
          w_abort_nxt = 1'b1;
        end
        if (i_mem_valid) begin
          o_data_we    = 1'b1;
          o_data_beat  = r_beat_cnt;
          o_data_wdata = i_mem_data;
          if (r_beat_cnt == LAST_BEAT) begin
            w_beat_cnt_nxt = '0;
            w_state_nxt    = ST_FILL;
          end else begin
            w_beat_cnt_nxt = r_beat_cnt + 1'b1;
          end
        end
      end

      ST_FILL: begin
        // IFetch always gets its done pulse; the tag is only validated when
        // no flush happened during the refill or in this very cycle.
        o_fill        = !r_abort && !i_clear;
        o_fill_paddr  = r_line_addr;
        o_refill_done = 1'b1;
        w_abort_nxt   = 1'b0;
        w_state_nxt   = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_ctrl
//   Scenario bench for the I-cache refill sequencer. Each refill pushes its
//   expected data-array writes and tag fill into queues as the stimulus is
//   driven; a negedge monitor pops and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_icache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        miss;
  logic [31:0] miss_paddr;
  logic        mem_ack;
  logic        mem_valid;
  logic [31:0] mem_data;

  logic        o_busy;
  logic        o_refill_done;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        o_data_we;
  logic [4:0]  o_data_idx;
  logic [1:0]  o_data_beat;
  logic [31:0] o_data_wdata;
  logic        o_fill;
  logic [31:0] o_fill_paddr;

  always #5 clk = ~clk;

  icache_refill_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_clear       (clear),
    .i_miss        (miss),
    .i_miss_paddr  (miss_paddr),
    .o_busy        (o_busy),
    .o_refill_done (o_refill_done),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (mem_ack),
    .i_mem_valid   (mem_valid),
    .i_mem_data    (mem_data),
    .o_data_we     (o_data_we),
    .o_data_idx    (o_data_idx),
    .o_data_beat   (o_data_beat),
    .o_data_wdata  (o_data_wdata),
    .o_fill        (o_fill),
    .o_fill_paddr  (o_fill_paddr)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [1:0]  beat;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [31:0] paddr;
    logic        fill;
  } fl_t;

  typedef struct {
    int          ack_delay;
    int          gap;
    int          clear_after;
    bit          clear_in_fill;
    bit          swap_miss;
    logic [31:0] swap_paddr;
    bit          keep_miss;
    int          rst_at_beat;
  } opt_t;

  wr_t wr_q[$];
  fl_t fl_q[$];
  wr_t mon_w;
  fl_t mon_f;
  bit  mon_en = 1'b0;
  int  n_checks = 0;
  int  n_pass   = 0;

  // Scoreboard: every data write and every done/fill pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en && o_data_we === 1'b1) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        $display("FAIL data_write: unexpected write idx=%h beat=%0d data=%h, none expected",
                 o_data_idx, o_data_beat, o_data_wdata);
      end else begin
        mon_w = wr_q.pop_front();
        if (o_data_idx !== mon_w.idx || o_data_beat !== mon_w.beat || o_data_wdata !== mon_w.data)
          $display("FAIL data_write: got idx=%h beat=%0d data=%h, want idx=%h beat=%0d data=%h",
                   o_data_idx, o_data_beat, o_data_wdata, mon_w.idx, mon_w.beat, mon_w.data);
        else
          n_pass++;
      end
    end
    if (mon_en && (o_refill_done === 1'b1 || o_fill === 1'b1)) begin
      n_checks++;
      if (fl_q.size() == 0) begin
        $display("FAIL tag_fill: unexpected done=%b fill=%b paddr=%h, none expected",
                 o_refill_done, o_fill, o_fill_paddr);
      end else begin
        mon_f = fl_q.pop_front();
        if (o_refill_done !== 1'b1 || o_fill !== mon_f.fill || o_fill_paddr !== mon_f.paddr)
          $display("FAIL tag_fill: got done=%b fill=%b paddr=%h, want done=1 fill=%b paddr=%h",
                   o_refill_done, o_fill, o_fill_paddr, mon_f.fill, mon_f.paddr);
        else
          n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic opt_t def_opts();
    opt_t o;
    o.ack_delay     = 0;
    o.gap           = 0;
    o.clear_after   = -1;
    o.clear_in_fill = 1'b0;
    o.swap_miss     = 1'b0;
    o.swap_paddr    = '0;
    o.keep_miss     = 1'b0;
    o.rst_at_beat   = -1;
    return o;
  endfunction

  // Drives one complete refill cycle by cycle; cycle 1 is the IDLE cycle that sees the miss.
  task automatic do_refill(input logic [31:0] paddr, input opt_t o, output int done_cyc);
    logic [31:0] line;
    logic [4:0]  idx;
    logic [31:0] d;
    wr_t         w;
    fl_t         f;
    int          cyc;
    bit          aborted;
    line     = {paddr[31:4], 4'h0};
    idx      = line[8:4];
    aborted  = 1'b0;
    done_cyc = -1;

    miss       = 1'b1;
    miss_paddr = paddr;
    cyc        = 1;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", o_busy);
    else n_pass++;
    tick(); cyc++;

    for (int k = 0; k <= o.ack_delay; k++) begin
      mem_ack   = (k == o.ack_delay);
      mem_valid = (k < o.ack_delay);
      mem_data  = 32'hBAD0_0000 + 32'(k);
      @(negedge clk);
      n_checks++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== line || o_busy !== 1'b1)
        $display("FAIL mem_req: got req=%b addr=%h busy=%b want req=1 addr=%h busy=1",
                 o_mem_req, o_mem_addr, o_busy, line);
      else n_pass++;
      tick(); cyc++;
    end
    mem_ack   = 1'b0;
    mem_valid = 1'b0;

    for (int b = 0; b < 4; b++) begin
      if (o.swap_miss) miss_paddr = o.swap_paddr;
      if (b > 0) begin
        for (int g = 0; g < o.gap; g++) begin
          @(negedge clk);
          n_checks++;
          if (o_busy !== 1'b1 || o_mem_req !== 1'b0 || o_data_we !== 1'b0)
            $display("FAIL recv_gap: got busy=%b req=%b we=%b want 1/0/0", o_busy, o_mem_req, o_data_we);
          else n_pass++;
          tick(); cyc++;
        end
      end
      d         = line ^ (32'(b + 1) * 32'h0101_0101);
      mem_valid = 1'b1;
      mem_data  = d;
      w.idx     = idx;
      w.beat    = 2'(b);
      w.data    = d;
      wr_q.push_back(w);
      if (b == o.rst_at_beat) begin
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        mem_valid = 1'b0;
        miss      = 1'b0;
        return;
      end
      @(negedge clk);
      n_checks++;
      if (o_busy !== 1'b1 || o_mem_req !== 1'b0)
        $display("FAIL recv_beat: got busy=%b req=%b want busy=1 req=0", o_busy, o_mem_req);
      else n_pass++;
      tick(); cyc++;
      mem_valid = 1'b0;
      if (b == o.clear_after) begin
        clear   = 1'b1;
        aborted = 1'b1;
        @(negedge clk);
        tick(); cyc++;
        clear = 1'b0;
      end
    end

    clear   = o.clear_in_fill;
    f.paddr = line;
    f.fill  = !(aborted || o.clear_in_fill);
    fl_q.push_back(f);
    @(negedge clk);
    n_checks++;
    if (o_refill_done !== 1'b1 || wr_q.size() != 0)
      $display("FAIL fill_cycle: got done=%b pending_writes=%0d want done=1 pending_writes=0",
               o_refill_done, wr_q.size());
    else n_pass++;
    done_cyc = cyc;
    tick();
    clear = 1'b0;
    if (!o.keep_miss) miss = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({o_busy, o_refill_done, o_mem_req, o_mem_addr, o_data_we, o_data_idx,
         o_data_beat, o_data_wdata, o_fill, o_fill_paddr} !== '0)
      $display("FAIL %s: got busy=%b done=%b req=%b addr=%h we=%b idx=%h beat=%0d wdata=%h fill=%b fpaddr=%h want all 0",
               name, o_busy, o_refill_done, o_mem_req, o_mem_addr, o_data_we, o_data_idx,
               o_data_beat, o_data_wdata, o_fill, o_fill_paddr);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    clear      = 1'b0;
    miss       = 1'b0;
    miss_paddr = '0;
    mem_ack    = 1'b0;
    mem_valid  = 1'b0;
    mem_data   = '0;
    tick();
    tick();
    @(negedge clk);
    check_all_zero("reset_outputs");
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
    tick();
  endtask

  task automatic test_basic_refill();
    int dc;
    do_refill(32'h0000_1234, def_opts(), dc);
    n_checks++;
    if (dc !== 7) $display("FAIL basic_latency: got done at cycle %0d want 7", dc);
    else n_pass++;
  endtask

  task automatic test_ack_delay_gaps();
    opt_t o;
    int   dc;
    o           = def_opts();
    o.ack_delay = 2;
    o.gap       = 1;
    do_refill(32'h0000_1234, o, dc);
    n_checks++;
    if (dc !== 12) $display("FAIL gap_latency: got done at cycle %0d want 12", dc);
    else n_pass++;
  endtask

  task automatic test_clear_abort();
    opt_t o;
    int   dc;
    o             = def_opts();
    o.clear_after = 1;
    do_refill(32'h0000_0A50, o, dc);
    // The abort must not leak into the following refill.
    do_refill(32'h0000_0B60, def_opts(), dc);
  endtask

  task automatic test_clear_idle_fill();
    opt_t o;
    int   dc;
    clear = 1'b1;
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) $display("FAIL clear_idle: got busy=%b want 0", o_busy);
    else n_pass++;
    tick();
    clear = 1'b0;
    do_refill(32'h0000_0C00, def_opts(), dc);
    o               = def_opts();
    o.clear_in_fill = 1'b1;
    do_refill(32'h0000_0D10, o, dc);
  endtask

  task automatic test_back_to_back();
    opt_t o;
    int   dc;
    o            = def_opts();
    o.swap_miss  = 1'b1;
    o.swap_paddr = 32'h0000_2000;
    o.keep_miss  = 1'b1;
    do_refill(32'h0000_1234, o, dc);
    do_refill(32'h0000_2000, def_opts(), dc);
    n_checks++;
    if (dc !== 7) $display("FAIL b2b_latency: got done at cycle %0d want 7", dc);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refill();
    opt_t o;
    int   dc;
    o             = def_opts();
    o.rst_at_beat = 2;
    do_refill(32'h0000_3340, o, dc);
    @(negedge clk);
    check_all_zero("reset_mid_refill");
    n_checks++;
    if (wr_q.size() != 0 || fl_q.size() != 0)
      $display("FAIL reset_scoreboard: got pending writes=%0d fills=%0d want 0/0", wr_q.size(), fl_q.size());
    else n_pass++;
    tick();
    do_refill(32'h0000_3350, def_opts(), dc);
    n_checks++;
    if (dc !== 7) $display("FAIL reset_recovery_latency: got done at cycle %0d want 7", dc);
    else n_pass++;
  endtask

  task automatic test_line_wrap();
    int dc;
    do_refill(32'hFFFF_FFFC, def_opts(), dc);
    // Beat numbering must restart at 0 for the next line.
    do_refill(32'h0000_0048, def_opts(), dc);
  endtask

  initial begin
    test_reset();
    test_basic_refill();
    test_ack_delay_gaps();
    test_clear_abort();
    test_clear_idle_fill();
    test_back_to_back();
    test_reset_mid_refill();
    test_line_wrap();
    tick();
    tick();
    n_checks++;
    if (wr_q.size() != 0 || fl_q.size() != 0)
      $display("FAIL scoreboard_drain: got pending writes=%0d fills=%0d want 0/0", wr_q.size(), fl_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
